// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data-side SRAM responder.
// Holds the FSM state enum, legal byte-enable masks and the alignment helper.
package data_sram_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dsram_state_e;

    localparam int WORD_BYTES = 4;

    localparam logic [3:0] SEL_B0  = 4'b0001;
    localparam logic [3:0] SEL_B1  = 4'b0010;
    localparam logic [3:0] SEL_B2  = 4'b0100;
    localparam logic [3:0] SEL_B3  = 4'b1000;
    localparam logic [3:0] SEL_HLO = 4'b0011;
    localparam logic [3:0] SEL_HHI = 4'b1100;
    localparam logic [3:0] SEL_W   = 4'b1111;

    // A full-word access must sit on a word boundary; any other
    // lane pattern outside the listed masks is a misaligned access.
    function automatic logic sel_misaligned(
        input logic [3:0] sel,
        input logic [1:0] off
    );
        logic legal;
        legal = (sel == SEL_B0)  || (sel == SEL_B1)  ||
                (sel == SEL_B2)  || (sel == SEL_B3)  ||
                (sel == SEL_HLO) || (sel == SEL_HHI) ||
                (sel == SEL_W);
        return !legal || ((sel == SEL_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// MEM-stage request/response bus between the pipeline and the data SRAM.
// master: drives ram_ce/we/sel/addr/wdata; slave: drives ram_data/ack/stall/err.
interface data_sram_responder_if;

    logic        ram_ce_i;
    logic        ram_we_i;
    logic [3:0]  ram_sel_i;
    logic [31:0] ram_addr_i;
    logic [31:0] ram_wdata_i;
    logic [31:0] ram_data_o;
    logic        ack_o;
    logic        stall_o;
    logic        err_o;

    modport master (
        output ram_ce_i, ram_we_i, ram_sel_i,
        output ram_addr_i, ram_wdata_i,
        input  ram_data_o, ack_o, stall_o, err_o
    );

    modport slave (
        input  ram_ce_i, ram_we_i, ram_sel_i,
        input  ram_addr_i, ram_wdata_i,
        output ram_data_o, ack_o, stall_o, err_o
    );

endinterface

// File: rtl/data_sram_responder_array.sv
// Single-port word RAM with four byte-lane write enables and registered read.
// Ports: clk_i, i_we, i_be[3:0], i_addr (word index), i_wdata, o_rdata.
module data_sram_responder_array #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we && i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder for the MEM stage: latches one request, waits
// LATENCY cycles, then acks with read data or commits the write.
// Ports: clk_i, rst_i (sync, active-high), bus (data_sram_responder_if.slave).
// Optional: DSRAM_ALIGN_CHECK_EN also flags misaligned accesses via err_o.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    data_sram_responder_if.slave   bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD =
        (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    dsram_state_e r_state;
    dsram_state_e w_next;

    logic          r_we;
    logic [3:0]    r_sel;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic          r_err;
    logic [3:0]    r_cnt;

    logic          w_accept;
    logic          w_in_range;
    logic          w_bad;
    logic          w_ack;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_idx;
    logic [31:0]   w_rdata;
    logic          w_unused_ok;

    assign w_accept = (r_state == IDLE) && bus.ram_ce_i;

    // BASE_ADDR is aligned to the array size, so the range test is a
    // compare of the bits above the word index.
    assign w_in_range =
        bus.ram_addr_i[31:AW+2] == BASE_ADDR[31:AW+2];

`ifdef DSRAM_ALIGN_CHECK_EN
    assign w_bad = !w_in_range ||
        sel_misaligned(bus.ram_sel_i, bus.ram_addr_i[1:0]);
`else
    assign w_bad = !w_in_range;
`endif

    assign w_unused_ok = ^bus.ram_addr_i[1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.ram_ce_i) begin
                    w_next = (LATENCY == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we    <= 1'b0;
            r_sel   <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
            r_cnt   <= 4'd0;
        end else if (w_accept) begin
            r_we    <= bus.ram_we_i;
            r_sel   <= bus.ram_sel_i;
            r_idx   <= bus.ram_addr_i[AW+1:2];
            r_wdata <= bus.ram_wdata_i;
            r_err   <= w_bad;
            r_cnt   <= CNT_LOAD;
        end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // The array read is registered, so in IDLE it is fed the live
    // address; the word is then ready by DONE even with LATENCY=0.
    assign w_mem_idx = (r_state == IDLE) ?
        bus.ram_addr_i[AW+1:2] : r_idx;
    assign w_mem_we  = (r_state == DONE) && r_we && !r_err;

    data_sram_responder_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk_i),
        .i_we    (w_mem_we),
        .i_be    (r_sel),
        .i_addr  (w_mem_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign w_ack = (r_state == DONE);

    always_comb begin
        bus.ack_o      = w_ack;
        bus.err_o      = w_ack && r_err;
        bus.ram_data_o = 32'd0;
        if (w_ack && !r_we && !r_err) begin
            bus.ram_data_o = w_rdata;
        end
        bus.stall_o = bus.ram_ce_i && !w_ack;
    end

endmodule
